// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: captures rdy/data_out, returns rdy_clr, pops FWFT.
// Optional registered almost-full flag compiled in with UART_RX_FIFO_WATERMARK_EN.
module uart_rx_fifo #(
    parameter int DEPTH = 16
`ifdef UART_RX_FIFO_WATERMARK_EN
    ,
    parameter int AFULL_LVL = DEPTH - 2
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_rdy,
    input  logic [7:0]                 rx_data,
    output logic                       rx_rdy_clr,
    output logic                       rd_valid,
    output logic [7:0]                 rd_data,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic                       afull
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_CLR = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic            rx_rdy_clr_reg;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg, count_next;
    logic            overflow_reg, overflow_next;
    logic            wr_attempt, wr_en, pop, drop;
    logic [7:0]      mem [DEPTH];

    // One write attempt per rdy assertion: only the IDLE->WAIT_CLR transition captures.
    always_comb begin
        state_next = state_reg;
        wr_attempt = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_rdy) begin
                    wr_attempt = 1'b1;
                    state_next = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (!rx_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign full     = (count_reg == DEPTH_W);
    assign rd_valid = (count_reg != '0);
    assign pop      = rd_valid & rd_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign wr_en    = wr_attempt & (~full | pop);
    assign drop     = wr_attempt & full & ~pop;

    always_comb begin
        count_next = count_reg;
        if (wr_en && !pop) begin
            count_next = count_reg + (AW + 1)'(1);
        end else if (pop && !wr_en) begin
            count_next = count_reg - (AW + 1)'(1);
        end
    end

    // Drop has priority over a simultaneous clear so no loss goes unreported.
    always_comb begin
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rx_rdy_clr_reg <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rx_rdy_clr_reg <= (state_next == WAIT_CLR);
            count_reg      <= count_next;
            overflow_reg   <= overflow_next;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= rx_data;
        end
    end

    assign rd_data    = mem[rd_ptr_reg];
    assign rx_rdy_clr = rx_rdy_clr_reg;
    assign count      = count_reg;
    assign overflow   = overflow_reg;

`ifdef UART_RX_FIFO_WATERMARK_EN
    localparam logic [AW:0] AFULL_W = (AW + 1)'(AFULL_LVL);
    logic afull_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            afull_reg <= 1'b0;
        end else begin
            afull_reg <= (count_next >= AFULL_W);
        end
    end

    assign afull = afull_reg;
`else
    assign afull = 1'b0;
`endif
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte buffer directly downstream of the UART receiver.
- Consumes the receiver's rdy/data_out pair and returns the rdy_clr pulse.
- Stores bytes in a synchronous FIFO and presents them to the host/bus side through a valid/ready pop interface.
- Decouples the bit-rate receive path from a slower or bursty consumer, and flags lost bytes.

Parameters:
- DEPTH, 16, number of byte entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.
- AFULL_LVL, DEPTH-2, almost-full threshold; used only when UART_RX_FIFO_WATERMARK_EN is defined.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_rdy  in  1  receiver "byte ready" level; held until cleared.
- rx_data  in  8  receiver data_out; stable while rx_rdy=1.
- rx_rdy_clr  out  1  clear request to receiver; registered.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  8  head entry, first-word-fall-through; valid when rd_valid=1.
- rd_ready  in  1  consumer pop; effective only when rd_valid=1.
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.
- afull  out  1  almost-full flag; see Optional Feature.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, wr_ptr=rd_ptr=0, count=0, rx_rdy_clr=0, overflow=0, afull=0. Consequently rd_valid=0 and full=0. rd_data is don't-care while empty. Reset mid-capture abandons that byte; the receiver's rdy stays pending and is captured after reset release.
- Capture FSM, 2 states:
  - IDLE: if rx_rdy=1, accept rx_data on this edge, go to WAIT_CLR, and set rx_rdy_clr=1 (high from the next cycle).
  - WAIT_CLR: hold rx_rdy_clr=1 until rx_rdy is sampled 0; then rx_rdy_clr=0 and go to IDLE.
  - Each rdy assertion therefore produces exactly one write attempt, never a duplicate.
  - Because the receiver clears rdy one cycle after seeing rdy_clr, WAIT_CLR lasts at least 2 cycles.
  - Capture-to-clear latency: rx_rdy_clr rises 1 cycle after rx_rdy is first sampled high.
- Write, IDLE and rx_rdy=1:
  - If not full, or if full and a pop happens in the same cycle: mem[wr_ptr]<=rx_data and wr_ptr increments.
  - Otherwise the byte is dropped and overflow<=1. rx_rdy_clr is still issued so the receiver is never stalled.
- Pop: rd_valid & rd_ready increments rd_ptr. rd_data=mem[rd_ptr], combinational from the registered pointer. A written byte appears on rd_data/rd_valid the cycle after its write edge; there is no same-cycle bypass when empty.
- Count: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop. Pointers wrap modulo DEPTH.
- Pop when empty is ignored; no pointer or count change.
- overflow: set by a drop, cleared by ovf_clr. If a drop and ovf_clr occur in the same cycle, set wins.
- full and rd_valid are decoded from count; no extra latency.

Optional Feature:
- Macro UART_RX_FIFO_WATERMARK_EN.
- Defined: afull is registered, equal to (next count >= AFULL_LVL), and updates on the same edge as count.
- Undefined: afull is tied 0, the AFULL_LVL logic is not compiled, and the port is still present.

Test Plan:
- Single byte: rx_rdy=1 with rx_data=8'hA5, receiver model clearing rdy one cycle after rx_rdy_clr -> rx_rdy_clr high for 2 cycles, rd_valid=1 with rd_data=8'hA5 on the next cycle, count=1; rd_ready pulse -> count=0, rd_valid=0.
- Ordering and wrap: write 8'h00..8'h17 (24 bytes) while popping after every 3rd write, DEPTH=16 -> all 24 bytes read out in order, count never exceeds 16, no overflow.
- Overflow: fill 16 bytes with no pops, then send 8'hEE -> full=1, overflow=1, rx_rdy_clr still pulsed, 8'hEE absent; then ovf_clr=1 -> overflow=0.
- Full with simultaneous pop: count=16, capture 8'h5A in the same cycle as rd_ready=1 -> byte accepted, count stays 16, overflow stays 0, 8'h5A read last.
- Async reset mid-operation: count=5 and FSM in WAIT_CLR, rst_n low between edges -> count=0, rd_valid=0, rx_rdy_clr=0 immediately; after release, the pending rx_rdy is captured once.
- Watermark (macro defined, AFULL_LVL=14): afull=0 at count 13, 1 at count 14, back to 0 after a pop to 13; with the macro undefined, afull=0 throughout.
